// File: rtl/env_pkg.sv
// env_pkg: shared width constant and state codes for the envelope follower slice.
package env_pkg;

    localparam int MAG_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ATTACK = 2'd1,
        ST_HOLD   = 2'd2,
        ST_DECAY  = 2'd3
    } state_t;

endpackage

// File: rtl/env_avg.sv
// env_avg: block averager; sums 2^AVG_SH magnitude samples and emits their mean once per block.
module env_avg
    import env_pkg::*;
#(
    parameter int AVG_SH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MAG_W-1:0] m,
    input  logic             iv,
    output logic [MAG_W-1:0] a,
    output logic             av
);

    localparam int ACC_W = MAG_W + AVG_SH;

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  sum;
    logic [AVG_SH-1:0] n;

    // Wide enough for a full block of full-scale samples, so the sum never wraps.
    assign sum = acc + ACC_W'(m);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            n   <= '0;
            a   <= '0;
            av  <= 1'b0;
        end else begin
            av <= 1'b0;
            if (iv) begin
                n <= n + AVG_SH'(1);
                if (&n) begin
                    a   <= sum[ACC_W-1:AVG_SH];
                    av  <= 1'b1;
                    acc <= '0;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

endmodule

// File: rtl/env_hold12.sv
// env_hold12: envelope follower with instant attack, programmable hold and exponential decay.
// Defining ENV_AVG_EN adds the env_avg block averager on outputs a/av; otherwise they are tied to 0.
module env_hold12
    import env_pkg::*;
#(
    parameter int HOLD_W   = 10,
    parameter int DECAY_SH = 4
`ifdef ENV_AVG_EN
    ,
    parameter int AVG_SH   = 8
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MAG_W-1:0]  m,
    input  logic              iv,
    input  logic [HOLD_W-1:0] hold,
    output logic [MAG_W-1:0]  e,
    output logic              ov,
    output logic [1:0]        st,
    output logic              pk,
    output logic [MAG_W-1:0]  a,
    output logic              av
);

    state_t            state_q, state_d;
    logic [MAG_W-1:0]  e_d;
    logic [MAG_W-1:0]  step;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              pk_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        e_d     = e;
        cnt_d   = cnt_q;
        state_d = state_q;
        pk_d    = 1'b0;

        // Minimum step of 1 lets small envelopes still reach zero; step <= e so no underflow.
        step = e >> DECAY_SH;
        if (step == '0) begin
            step = MAG_W'(1);
        end

        if (iv) begin
            if (m > e) begin
                e_d     = m;
                cnt_d   = hold;
                state_d = ST_ATTACK;
                pk_d    = 1'b1;
            end else if (cnt_q != '0) begin
                cnt_d   = cnt_q - HOLD_W'(1);
                state_d = ST_HOLD;
            end else if (e != '0) begin
                e_d     = e - step;
                state_d = ST_DECAY;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e       <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            pk      <= 1'b0;
            ov      <= 1'b0;
        end else begin
            e       <= e_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            pk      <= pk_d;
            ov      <= iv;
        end
    end

    assign st = state_q;

`ifdef ENV_AVG_EN
    env_avg #(
        .AVG_SH (AVG_SH)
    ) u_avg (
        .clk (clk),
        .rst (rst),
        .m   (m),
        .iv  (iv),
        .a   (a),
        .av  (av)
    );
`else
    assign a  = '0;
    assign av = 1'b0;
`endif

endmodule

// File: tb/tb_env_hold12.sv
// tb_env_hold12: vector table, hand-written corner sequences and a randomized run against a reference model.
module tb_env_hold12;

    localparam int HOLD_W   = 10;
    localparam int DECAY_SH = 4;
`ifdef ENV_AVG_EN
    localparam bit AVG_ON  = 1'b1;
    localparam int AVG_SH  = 2;
`else
    localparam bit AVG_ON  = 1'b0;
    localparam int AVG_SH  = 8;
`endif
    localparam int AVG_LEN = 1 << AVG_SH;

    logic              clk;
    logic              rst;
    logic [11:0]       m;
    logic              iv;
    logic [HOLD_W-1:0] hold;
    logic [11:0]       e;
    logic              ov;
    logic [1:0]        st;
    logic              pk;
    logic [11:0]       a;
    logic              av;

    env_hold12 #(
        .HOLD_W   (HOLD_W),
        .DECAY_SH (DECAY_SH)
`ifdef ENV_AVG_EN
        ,
        .AVG_SH   (AVG_SH)
`endif
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .m    (m),
        .iv   (iv),
        .hold (hold),
        .e    (e),
        .ov   (ov),
        .st   (st),
        .pk   (pk),
        .a    (a),
        .av   (av)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: envelope rules evaluated with plain integer arithmetic.
    int  me, mc, mst, ma;
    bit  mpk, mov, mav;
    int  q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input int ee, input int es, input bit epk, input bit eov);
        check({tag, ".e"},  int'(e),  ee);
        check({tag, ".st"}, int'(st), es);
        check({tag, ".pk"}, int'(pk), int'(epk));
        check({tag, ".ov"}, int'(ov), int'(eov));
    endtask

    task automatic check_avg(input string tag, input int ea, input bit eav);
        check({tag, ".a"},  int'(a),  ea);
        check({tag, ".av"}, int'(av), int'(eav));
    endtask

    task automatic model_reset();
        me = 0; mc = 0; mst = 0; ma = 0;
        mpk = 0; mov = 0; mav = 0;
        q.delete();
    endtask

    task automatic model_step(input bit v, input int mm, input int hh);
        int d;
        int sum;
        mov = v;
        mpk = 0;
        mav = 0;
        if (v) begin
            if (mm > me) begin
                me = mm; mc = hh; mst = 1; mpk = 1;
            end else if (mc > 0) begin
                mc = mc - 1; mst = 2;
            end else if (me > 0) begin
                d = me / (1 << DECAY_SH);
                if (d < 1) d = 1;
                me = me - d; mst = 3;
            end else begin
                mst = 0;
            end
            if (AVG_ON) begin
                q.push_back(mm);
                if (q.size() == AVG_LEN) begin
                    sum = 0;
                    foreach (q[i]) sum += q[i];
                    ma = sum / AVG_LEN;
                    mav = 1;
                    q.delete();
                end
            end
        end
    endtask

    // Inputs change 1 time unit after an edge; outputs are read 1 time unit after the next edge.
    task automatic drive(input bit v, input int mm, input int hh);
        iv   = v;
        m    = 12'(mm);
        hold = HOLD_W'(hh);
        @(posedge clk);
        #1;
        model_step(v, mm, hh);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        iv   = 1'b0;
        m    = '0;
        hold = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit iv;
        int m;
        int hold;
        int e;
        int st;
        bit pk;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1, 1414, 3, 1414, 1, 1};
        tbl[1]  = '{1,    0, 3, 1414, 2, 0};
        tbl[2]  = '{0,    0, 3, 1414, 2, 0};
        tbl[3]  = '{1,    0, 3, 1414, 2, 0};
        tbl[4]  = '{1,    0, 3, 1414, 2, 0};
        tbl[5]  = '{1,    0, 3, 1326, 3, 0};
        tbl[6]  = '{1,    0, 3, 1244, 3, 0};
        tbl[7]  = '{1, 1300, 2, 1300, 1, 1};
        tbl[8]  = '{1, 1300, 2, 1300, 2, 0};
        tbl[9]  = '{1,    0, 2, 1300, 2, 0};
        tbl[10] = '{1,    0, 2, 1219, 3, 0};
        tbl[11] = '{1, 1219, 5, 1143, 3, 0};

        rst = 1'b1; iv = 1'b0; m = '0; hold = '0;
        do_reset();
        check_out("reset", 0, 0, 0, 0);
        check_avg("reset", 0, 0);

        // Peak, hold with a one-clock gap, decay, re-attack and equal-magnitude sample.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].iv, tbl[i].m, tbl[i].hold);
            check_out($sformatf("tbl%0d", i), tbl[i].e, tbl[i].st, tbl[i].pk, tbl[i].iv);
        end

        // Asynchronous reset between edges while decaying.
        #2 rst = 1'b1;
        #1;
        check_out("async_rst", 0, 0, 0, 0);
        check_avg("async_rst", 0, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(1, 14, 4);
        check_out("after_rst", 14, 1, 1, 1);

        // Small-value tail with hold=0 at capture.
        do_reset();
        drive(1, 5, 0);
        check_out("tail_peak", 5, 1, 1, 1);
        for (int k = 4; k >= 0; k--) begin
            drive(1, 0, 0);
            check_out($sformatf("tail%0d", k), k, 3, 0, 1);
        end
        repeat (2) begin
            drive(1, 0, 0);
            check_out("tail_idle", 0, 0, 0, 1);
        end

        // Idle gap inside HOLD freezes the countdown.
        do_reset();
        drive(1, 100, 3);
        check_out("gap_peak", 100, 1, 1, 1);
        drive(1, 0, 3);
        check_out("gap_hold0", 100, 2, 0, 1);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 3);
            check_out($sformatf("gap_idle%0d", k), 100, 2, 0, 0);
        end
        drive(1, 0, 3);
        check_out("gap_hold1", 100, 2, 0, 1);
        drive(1, 0, 3);
        check_out("gap_hold2", 100, 2, 0, 1);
        drive(1, 0, 3);
        check_out("gap_decay", 94, 3, 0, 1);

        // Block averager: 10,20,30,40 then 4x100 (tied to 0 when the feature is built out).
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            drive(1, 10 * k, 0);
            if (k < 4) check_avg($sformatf("avg_a%0d", k), 0, 0);
            else       check_avg("avg_a4", AVG_ON ? 25 : 0, AVG_ON);
        end
        for (int k = 1; k <= 4; k++) begin
            drive(1, 100, 0);
            if (k < 4) check_avg($sformatf("avg_b%0d", k), AVG_ON ? 25 : 0, 0);
            else       check_avg("avg_b4", AVG_ON ? 100 : 0, AVG_ON);
        end
        drive(0, 0, 0);
        check_avg("avg_idle", AVG_ON ? 100 : 0, 0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int r;
            int mm;
            bit v;
            r  = int'($urandom_range(0, 7));
            mm = (r == 0) ? int'($urandom_range(0, 4095)) :
                 (r == 1) ? int'($urandom_range(0, 20)) : 0;
            v  = ($urandom_range(0, 3) != 0);
            drive(v, mm, int'($urandom_range(0, 6)));
            check_out($sformatf("rnd%0d", i), me, mst, mpk, mov);
            check_avg($sformatf("rnd%0d", i), ma, mav);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
